// File: rtl/bp_cfg_param_pkg.sv
// Shared types and compiled-in processor configurations for the config parameter responder.
// all_cfgs_gp is the table of configurations a build can expose; bp_params_e selects an entry.
package bp_cfg_param_pkg;

    localparam int num_cfg_fields_gp  = 39;
    localparam int cfg_value_width_gp = 32;
    localparam int cfg_data_width_gp  = 64;
    localparam int cfg_field_width_gp = 6;

    typedef enum logic {
        e_cfg_read = 1'b0,
        e_cfg_dump = 1'b1
    } bp_cfg_param_op_e;

    typedef enum logic {
        e_bp_single_core_cfg = 1'b0,
        e_bp_dual_core_cfg   = 1'b1
    } bp_params_e;

    typedef enum logic [cfg_field_width_gp-1:0] {
        e_cfg_cc_x_dim                  = 6'd0,
        e_cfg_cc_y_dim                  = 6'd1,
        e_cfg_ic_x_dim                  = 6'd2,
        e_cfg_ic_y_dim                  = 6'd3,
        e_cfg_mc_x_dim                  = 6'd4,
        e_cfg_mc_y_dim                  = 6'd5,
        e_cfg_cac_x_dim                 = 6'd6,
        e_cfg_sac_x_dim                 = 6'd7,
        e_cfg_num_core                  = 6'd8,
        e_cfg_num_io                    = 6'd9,
        e_cfg_num_l2e                   = 6'd10,
        e_cfg_num_cce                   = 6'd11,
        e_cfg_num_lce                   = 6'd12,
        e_cfg_vaddr_width               = 6'd13,
        e_cfg_paddr_width               = 6'd14,
        e_cfg_lce_sets                  = 6'd15,
        e_cfg_lce_assoc                 = 6'd16,
        e_cfg_cce_block_width           = 6'd17,
        e_cfg_branch_metadata_fwd_width = 6'd18,
        e_cfg_btb_tag_width             = 6'd19,
        e_cfg_btb_idx_width             = 6'd20,
        e_cfg_bht_idx_width             = 6'd21,
        e_cfg_ghist_width               = 6'd22,
        e_cfg_itlb_els                  = 6'd23,
        e_cfg_dtlb_els                  = 6'd24,
        e_cfg_l2_en                     = 6'd25,
        e_cfg_l2_sets                   = 6'd26,
        e_cfg_l2_assoc                  = 6'd27,
        e_cfg_l2_outstanding_reqs       = 6'd28,
        e_cfg_fe_queue_fifo_els         = 6'd29,
        e_cfg_fe_cmd_fifo_els           = 6'd30,
        e_cfg_async_coh_clk             = 6'd31,
        e_cfg_coh_noc_flit_width        = 6'd32,
        e_cfg_coh_noc_cid_width         = 6'd33,
        e_cfg_coh_noc_len_width         = 6'd34,
        e_cfg_mem_noc_flit_width        = 6'd35,
        e_cfg_mem_noc_cid_width         = 6'd36,
        e_cfg_io_noc_flit_width         = 6'd37,
        e_cfg_io_noc_len_width          = 6'd38,
        e_cfg_checksum                  = 6'd63
    } bp_cfg_field_e;

    typedef logic [cfg_value_width_gp-1:0] cfg_val_t;

    // Member order is the field ID order: the first member (ID 0) sits in the MSBs.
    typedef struct packed {
        cfg_val_t cc_x_dim;
        cfg_val_t cc_y_dim;
        cfg_val_t ic_x_dim;
        cfg_val_t ic_y_dim;
        cfg_val_t mc_x_dim;
        cfg_val_t mc_y_dim;
        cfg_val_t cac_x_dim;
        cfg_val_t sac_x_dim;
        cfg_val_t num_core;
        cfg_val_t num_io;
        cfg_val_t num_l2e;
        cfg_val_t num_cce;
        cfg_val_t num_lce;
        cfg_val_t vaddr_width;
        cfg_val_t paddr_width;
        cfg_val_t lce_sets;
        cfg_val_t lce_assoc;
        cfg_val_t cce_block_width;
        cfg_val_t branch_metadata_fwd_width;
        cfg_val_t btb_tag_width;
        cfg_val_t btb_idx_width;
        cfg_val_t bht_idx_width;
        cfg_val_t ghist_width;
        cfg_val_t itlb_els;
        cfg_val_t dtlb_els;
        cfg_val_t l2_en;
        cfg_val_t l2_sets;
        cfg_val_t l2_assoc;
        cfg_val_t l2_outstanding_reqs;
        cfg_val_t fe_queue_fifo_els;
        cfg_val_t fe_cmd_fifo_els;
        cfg_val_t async_coh_clk;
        cfg_val_t coh_noc_flit_width;
        cfg_val_t coh_noc_cid_width;
        cfg_val_t coh_noc_len_width;
        cfg_val_t mem_noc_flit_width;
        cfg_val_t mem_noc_cid_width;
        cfg_val_t io_noc_flit_width;
        cfg_val_t io_noc_len_width;
    } bp_proc_param_s;

    typedef struct packed {
        logic [cfg_field_width_gp-1:0] field;
        logic [cfg_data_width_gp-1:0]  data;
        logic                          err;
        logic                          last;
    } bp_cfg_param_resp_s;

    localparam bp_proc_param_s all_cfgs_gp [2] = '{
        '{cc_x_dim: 32'd1, cc_y_dim: 32'd1, ic_x_dim: 32'd1, ic_y_dim: 32'd1,
          mc_x_dim: 32'd1, mc_y_dim: 32'd1, cac_x_dim: 32'd0, sac_x_dim: 32'd0,
          num_core: 32'd1, num_io: 32'd1, num_l2e: 32'd1, num_cce: 32'd1, num_lce: 32'd2,
          vaddr_width: 32'd39, paddr_width: 32'd40, lce_sets: 32'd128, lce_assoc: 32'd8,
          cce_block_width: 32'd256, branch_metadata_fwd_width: 32'd35, btb_tag_width: 32'd9,
          btb_idx_width: 32'd6, bht_idx_width: 32'd9, ghist_width: 32'd2, itlb_els: 32'd8,
          dtlb_els: 32'd8, l2_en: 32'd1, l2_sets: 32'd128, l2_assoc: 32'd8,
          l2_outstanding_reqs: 32'd8, fe_queue_fifo_els: 32'd8, fe_cmd_fifo_els: 32'd4,
          async_coh_clk: 32'd0, coh_noc_flit_width: 32'd128, coh_noc_cid_width: 32'd2,
          coh_noc_len_width: 32'd3, mem_noc_flit_width: 32'd64, mem_noc_cid_width: 32'd2,
          io_noc_flit_width: 32'd64, io_noc_len_width: 32'd4},
        '{cc_x_dim: 32'd2, cc_y_dim: 32'd1, ic_x_dim: 32'd2, ic_y_dim: 32'd1,
          mc_x_dim: 32'd2, mc_y_dim: 32'd1, cac_x_dim: 32'd0, sac_x_dim: 32'd0,
          num_core: 32'd2, num_io: 32'd1, num_l2e: 32'd2, num_cce: 32'd2, num_lce: 32'd4,
          vaddr_width: 32'd39, paddr_width: 32'd40, lce_sets: 32'd128, lce_assoc: 32'd8,
          cce_block_width: 32'd256, branch_metadata_fwd_width: 32'd35, btb_tag_width: 32'd9,
          btb_idx_width: 32'd6, bht_idx_width: 32'd9, ghist_width: 32'd2, itlb_els: 32'd8,
          dtlb_els: 32'd8, l2_en: 32'd1, l2_sets: 32'd128, l2_assoc: 32'd8,
          l2_outstanding_reqs: 32'd8, fe_queue_fifo_els: 32'd8, fe_cmd_fifo_els: 32'd4,
          async_coh_clk: 32'd0, coh_noc_flit_width: 32'd128, coh_noc_cid_width: 32'd3,
          coh_noc_len_width: 32'd3, mem_noc_flit_width: 32'd64, mem_noc_cid_width: 32'd2,
          io_noc_flit_width: 32'd64, io_noc_len_width: 32'd4}
    };

    // XOR of every field value; folds to a constant because cfg is always elaboration-time.
    function automatic cfg_val_t cfg_checksum(input bp_proc_param_s cfg);
        cfg_val_t cs;
        cs = '0;
        for (int i = 0; i < num_cfg_fields_gp; i++) begin
            cs ^= cfg[(num_cfg_fields_gp-1-i)*cfg_value_width_gp +: cfg_value_width_gp];
        end
        return cs;
    endfunction

endpackage

// File: rtl/bp_cfg_param_mux.sv
// Combinational field selector: configuration struct + field ID -> zero-extended value and range flag.
// Honours BP_CFG_PARAM_CHECKSUM_EN, which makes ID 63 a valid field carrying the XOR checksum.
module bp_cfg_param_mux
    import bp_cfg_param_pkg::*;
#(
    parameter int data_width_p = cfg_data_width_gp
) (
    input  bp_proc_param_s                 cfg,
    input  logic [cfg_field_width_gp-1:0]  field,
    output logic [data_width_p-1:0]        data,
    output logic                           err
);

    localparam logic [cfg_field_width_gp-1:0] num_fields_lp = cfg_field_width_gp'(num_cfg_fields_gp);

    cfg_val_t vals [num_cfg_fields_gp];

    generate
        for (genvar gi = 0; gi < num_cfg_fields_gp; gi++) begin : g_vals
            assign vals[gi] = cfg[(num_cfg_fields_gp-1-gi)*cfg_value_width_gp +: cfg_value_width_gp];
        end
    endgenerate

    always_comb begin
        data = '0;
        err  = 1'b1;
        if (field < num_fields_lp) begin
            data = data_width_p'(vals[field]);
            err  = 1'b0;
        end
`ifdef BP_CFG_PARAM_CHECKSUM_EN
        else if (field == e_cfg_checksum) begin
            data = data_width_p'(cfg_checksum(cfg));
            err  = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/bp_cfg_param_responder.sv
// Host-facing responder exposing one compiled-in processor configuration as readable fields.
// Optional BP_CFG_PARAM_CHECKSUM_EN appends a checksum beat (ID 63) to dumps and allows reading it.
module bp_cfg_param_responder
    import bp_cfg_param_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_single_core_cfg,
    parameter int         data_width_p = cfg_data_width_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           cmd_v_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_op_i,
    input  logic [cfg_field_width_gp-1:0]  cmd_field_i,
    output logic                           resp_v_o,
    input  logic                           resp_yumi_i,
    output logic [cfg_field_width_gp-1:0]  resp_field_o,
    output logic [data_width_p-1:0]        resp_data_o,
    output logic                           resp_err_o,
    output logic                           resp_last_o
);

    localparam bp_proc_param_s cfg_lp = all_cfgs_gp[bp_params_p];
    localparam logic [cfg_field_width_gp-1:0] num_fields_lp = cfg_field_width_gp'(num_cfg_fields_gp);
`ifdef BP_CFG_PARAM_CHECKSUM_EN
    localparam logic [cfg_field_width_gp-1:0] last_beat_lp = num_fields_lp;
`else
    localparam logic [cfg_field_width_gp-1:0] last_beat_lp = num_fields_lp - 6'd1;
`endif

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_resp = 2'd1,
        e_dump = 2'd2
    } state_e;

    state_e                        state_reg, state_next;
    logic [cfg_field_width_gp-1:0] cnt_reg, cnt_next, cnt_inc;
    logic                          resp_v_reg, resp_v_next;
    bp_cfg_param_resp_s            resp_reg, resp_next;

    logic [cfg_field_width_gp-1:0] sel_field;
    logic [cfg_data_width_gp-1:0]  mux_data;
    logic                          mux_err;
    logic                          cmd_accept;
    logic                          is_read;

    // Dump beat index to field ID; the beat after the last real field is the checksum.
    function automatic logic [cfg_field_width_gp-1:0] beat_field(input logic [cfg_field_width_gp-1:0] beat);
`ifdef BP_CFG_PARAM_CHECKSUM_EN
        return (beat == num_fields_lp) ? e_cfg_checksum : beat;
`else
        return beat;
`endif
    endfunction

    assign cmd_ready_o = (state_reg == e_idle) & ~reset_i;
    assign cmd_accept  = cmd_v_i & cmd_ready_o;
    assign is_read     = (bp_cfg_param_op_e'(cmd_op_i) == e_cfg_read);
    assign cnt_inc     = cnt_reg + 6'd1;

    always_comb begin
        sel_field = beat_field(cnt_inc);
        if (state_reg == e_idle) begin
            sel_field = is_read ? cmd_field_i : '0;
        end
    end

    bp_cfg_param_mux #(
        .data_width_p (cfg_data_width_gp)
    ) u_mux (
        .cfg   (cfg_lp),
        .field (sel_field),
        .data  (mux_data),
        .err   (mux_err)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        resp_v_next = resp_v_reg;
        resp_next   = resp_reg;
        unique case (state_reg)
            e_idle: begin
                if (cmd_accept) begin
                    resp_v_next = 1'b1;
                    if (is_read) begin
                        resp_next  = '{field: sel_field, data: mux_data, err: mux_err, last: 1'b1};
                        state_next = e_resp;
                    end else begin
                        cnt_next   = '0;
                        resp_next  = '{field: sel_field, data: mux_data, err: 1'b0,
                                      last: (last_beat_lp == '0)};
                        state_next = e_dump;
                    end
                end
            end
            e_resp: begin
                if (resp_yumi_i) begin
                    resp_v_next = 1'b0;
                    state_next  = e_idle;
                end
            end
            e_dump: begin
                if (resp_yumi_i) begin
                    if (cnt_reg == last_beat_lp) begin
                        resp_v_next = 1'b0;
                        state_next  = e_idle;
                    end else begin
                        cnt_next  = cnt_inc;
                        resp_next = '{field: sel_field, data: mux_data, err: 1'b0,
                                      last: (cnt_inc == last_beat_lp)};
                    end
                end
            end
            default: begin
                resp_v_next = 1'b0;
                state_next  = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg  <= e_idle;
            cnt_reg    <= '0;
            resp_v_reg <= 1'b0;
            resp_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            resp_v_reg <= resp_v_next;
            resp_reg   <= resp_next;
        end
    end

    // A consumer acknowledging an absent response is a protocol error upstream.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(resp_yumi_i && !resp_v_reg));
        end
    end

    assign resp_v_o     = resp_v_reg;
    assign resp_field_o = resp_reg.field;
    assign resp_data_o  = data_width_p'(resp_reg.data);
    assign resp_err_o   = resp_reg.err;
    assign resp_last_o  = resp_reg.last;

endmodule

// File: tb/tb_bp_cfg_param_responder.sv
// Scoreboard bench for bp_cfg_param_responder: directed plus random reads/dumps, randomized yumi.
// Expected beats come from a plain field-value table of the single-core configuration.
module tb_bp_cfg_param_responder;

    logic        clk;
    logic        reset_i;
    logic        cmd_v_i;
    logic        cmd_ready_o;
    logic        cmd_op_i;
    logic [5:0]  cmd_field_i;
    logic        resp_v_o;
    logic        resp_yumi_i;
    logic [5:0]  resp_field_o;
    logic [63:0] resp_data_o;
    logic        resp_err_o;
    logic        resp_last_o;

    bp_cfg_param_responder dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cmd_v_i      (cmd_v_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_field_i  (cmd_field_i),
        .resp_v_o     (resp_v_o),
        .resp_yumi_i  (resp_yumi_i),
        .resp_field_o (resp_field_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .resp_last_o  (resp_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [63:0] d;
        logic        e;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   yumi_mode = 0;   // 0 always, 1 every third cycle, 2 random
    int   cyc = 0;

    // Single-core configuration, field ID order.
    int unsigned cfg_vals [39] = '{
        1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 2, 39, 40, 128, 8, 256, 35, 9,
        6, 9, 2, 8, 8, 1, 128, 8, 8, 8, 4, 0, 128, 2, 3, 64, 2, 64, 4
    };

    function automatic logic [63:0] checksum();
        logic [63:0] cs = 0;
        foreach (cfg_vals[i]) cs ^= 64'(cfg_vals[i]);
        return cs;
    endfunction

    function automatic bit cs_en();
`ifdef BP_CFG_PARAM_CHECKSUM_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_read(input int f);
        exp_t x;
        x.f = 6'(f); x.l = 1'b1;
        if (f < 39) begin x.d = 64'(cfg_vals[f]); x.e = 1'b0; end
        else if (f == 63 && cs_en()) begin x.d = checksum(); x.e = 1'b0; end
        else begin x.d = 0; x.e = 1'b1; end
        q.push_back(x);
    endtask

    task automatic push_dump();
        exp_t x;
        for (int i = 0; i < 39; i++) begin
            x.f = 6'(i); x.d = 64'(cfg_vals[i]); x.e = 1'b0;
            x.l = (i == 38) && !cs_en();
            q.push_back(x);
        end
        if (cs_en()) begin
            x.f = 6'd63; x.d = checksum(); x.e = 1'b0; x.l = 1'b1;
            q.push_back(x);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Issue one command; returns at the negedge after acceptance, having checked 1-cycle latency.
    task automatic do_cmd(input logic op, input int f);
        int n = 0;
        if (op) push_dump(); else push_read(f);
        @(negedge clk);
        while (!cmd_ready_o && n < 500) begin @(negedge clk); n++; end
        if (!cmd_ready_o) begin
            total++; bad++;
            $display("FAIL cmd_ready timeout: got 0 want 1");
        end
        cmd_v_i = 1'b1; cmd_op_i = op; cmd_field_i = 6'(f);
        @(posedge clk); #1;
        cmd_v_i = 1'b0; cmd_field_i = 6'($urandom_range(0, 63));
        @(negedge clk);
        chk("latency resp_v", 64'(resp_v_o), 64'd1);
        $display("cmd op=%0d field=%0d accepted", op, f);
    endtask

    // Monitor: compare every presented beat with the queue head; pop only when yumi is given.
    initial begin
        bit take;
        resp_yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_i || !resp_v_o) begin
                resp_yumi_i = 1'b0;
            end else begin
                total++;
                if (cmd_ready_o) begin
                    bad++;
                    $display("FAIL ready_while_busy: got 1 want 0");
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got f=%0d d=%0h want none", resp_field_o, resp_data_o);
                end else if (resp_field_o !== q[0].f || resp_data_o !== q[0].d ||
                             resp_err_o !== q[0].e || resp_last_o !== q[0].l) begin
                    bad++;
                    $display("FAIL beat: got f=%0d d=%0h e=%0b l=%0b want f=%0d d=%0h e=%0b l=%0b",
                             resp_field_o, resp_data_o, resp_err_o, resp_last_o,
                             q[0].f, q[0].d, q[0].e, q[0].l);
                end
                case (yumi_mode)
                    0:       take = 1'b1;
                    1:       take = (cyc % 3 == 0);
                    default: take = 1'($urandom_range(0, 1));
                endcase
                resp_yumi_i = take;
                if (take) begin
                    $display("beat f=%0d d=%0h e=%0b l=%0b consumed", resp_field_o, resp_data_o,
                             resp_err_o, resp_last_o);
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset_i = 1'b1; cmd_v_i = 1'b0; cmd_op_i = 1'b0; cmd_field_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_v", 64'(resp_v_o), 64'd0);
        chk("reset data", resp_data_o, 64'd0);
        chk("reset field", 64'(resp_field_o), 64'd0);
        chk("reset err_last", 64'({resp_err_o, resp_last_o}), 64'd0);
        chk("ready in reset", 64'(cmd_ready_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready after reset", 64'(cmd_ready_o), 64'd1);

        // Single read, then idle two cycles after acceptance.
        yumi_mode = 0;
        do_cmd(1'b0, 0);
        @(negedge clk);
        chk("ready after yumi", 64'(cmd_ready_o), 64'd1);
        chk("resp_v after yumi", 64'(resp_v_o), 64'd0);

        do_cmd(1'b0, 15);
        do_cmd(1'b0, 17);
        do_cmd(1'b0, 38);
        do_cmd(1'b0, 45);
        do_cmd(1'b0, 63);
        do_cmd(1'b0, 39);

        do_cmd(1'b1, 0);
        yumi_mode = 1;
        do_cmd(1'b1, 0);
        yumi_mode = 2;
        do_cmd(1'b0, 5);

        // Reset while dump beat 10 is presented.
        yumi_mode = 0;
        do_cmd(1'b1, 0);
        n = 0;
        while (!(resp_v_o && resp_field_o == 6'd10) && n < 200) begin @(posedge clk); #1; n++; end
        chk("reach beat 10", 64'(resp_field_o), 64'd10);
        reset_i = 1'b1;
        @(posedge clk); #1;
        q.delete();
        chk("abort resp_v", 64'(resp_v_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("abort idle ready", 64'(cmd_ready_o), 64'd1);
        do_cmd(1'b0, 1);

        for (int i = 0; i < 30; i++) begin
            yumi_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) do_cmd(1'b1, 0);
            else do_cmd(1'b0, $urandom_range(0, 63));
        end

        n = 0;
        while (q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
        chk("final idle", 64'({resp_v_o, cmd_ready_o}), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
